// File: rtl/i2c_target.sv
// I2C target with oversampled SCL/SDA, 7-bit address match and an auto-incrementing
// register bank that is also readable and writable from a host port.
module i2c_target #(
  parameter logic [6:0]  ADDR        = 7'h50,
  parameter int unsigned NREGS       = 8,
  parameter int unsigned PTR_W       = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             busy,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic [PTR_W-1:0] rx_index,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata
);

  localparam int unsigned      CNT_W = 4;
  localparam logic [CNT_W-1:0] BIT8  = CNT_W'(8);
  localparam logic [CNT_W-1:0] BIT9  = CNT_W'(9);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_WR_PTR, S_WR_DATA, S_RD_DATA, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_c, stop_c;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sh_q, sh_d;
  logic [6:0]       tx_q, tx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             oe_q, oe_d, busy_q, busy_d, rw_q, rw_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic [PTR_W-1:0] rx_index_q, rx_index_d;
  logic             bus_we_c;
  logic [7:0]       bank_ptr_c;
  logic [7:0]       bank [NREGS];

  // Pin synchronisers followed by a previous-level flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev;
  assign scl_fall   = ~scl_s & scl_prev;
  assign start_c    = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_c     = scl_s & scl_prev & ~sda_prev & sda_s;
  assign bank_ptr_c = bank[ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_index_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_index_q <= rx_index_d;
    end
  end

  // cnt counts sampled bits; 8 = byte complete (ACK slot), 9 = ACK clock has risen
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_index_d = rx_index_q;
    bus_we_c   = 1'b0;
    if (start_c) begin
      state_d = S_ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (stop_c) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR, S_WR_PTR, S_WR_DATA: begin
          if (scl_rise) begin
            if (cnt_q < BIT8) begin
              sh_d  = {sh_q[6:0], sda_s};
              cnt_d = cnt_q + CNT_W'(1);
            end else if (cnt_q == BIT8) begin
              cnt_d = BIT9;
            end
          end else if (scl_fall && cnt_q == BIT8) begin
            oe_d = 1'b1;
            if (state_q == S_ADDR) begin
              if (sh_q[7:1] == ADDR) begin
                busy_d  = 1'b1;
                rw_d    = sh_q[0];
                state_d = S_ACK_A;
              end else begin
                oe_d    = 1'b0;
                cnt_d   = '0;
                state_d = S_IGNORE;
              end
            end else if (state_q == S_WR_PTR) begin
              ptr_d = sh_q[PTR_W-1:0];
            end else begin
              bus_we_c   = 1'b1;
              rx_valid_d = 1'b1;
              rx_data_d  = sh_q;
              rx_index_d = ptr_q;
              ptr_d      = ptr_q + PTR_W'(1);
            end
          end else if (scl_fall && cnt_q == BIT9) begin
            oe_d  = 1'b0;
            cnt_d = '0;
            if (state_q == S_WR_PTR) state_d = S_WR_DATA;
          end
        end
        S_ACK_A: begin
          if (scl_rise) begin
            cnt_d = BIT9;
          end else if (scl_fall && cnt_q == BIT9) begin
            cnt_d = '0;
            if (rw_q) begin
              state_d = S_RD_DATA;
              tx_d    = bank_ptr_c[6:0];
              oe_d    = ~bank_ptr_c[7];
            end else begin
              state_d = S_WR_PTR;
              oe_d    = 1'b0;
            end
          end
        end
        S_RD_DATA: begin
          if (scl_rise) begin
            if (cnt_q < BIT8) begin
              cnt_d = cnt_q + CNT_W'(1);
            end else if (!sda_s) begin
              ptr_d = ptr_q + PTR_W'(1);
              cnt_d = BIT9;
            end else begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
              cnt_d   = '0;
            end
          end else if (scl_fall) begin
            if (cnt_q == BIT9) begin
              tx_d  = bank_ptr_c[6:0];
              oe_d  = ~bank_ptr_c[7];
              cnt_d = '0;
            end else if (cnt_q == BIT8) begin
              oe_d = 1'b0;
            end else if (cnt_q != '0) begin
              oe_d = ~tx_q[6];
              tx_d = {tx_q[5:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Bus write is issued after the host write so it wins on an index collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) bank[i] <= '0;
    end else begin
      if (host_we) bank[host_addr] <= host_wdata;
      if (bus_we_c) bank[ptr_q] <= sh_q;
    end
  end

  assign sda_oe     = oe_q;
  assign busy       = busy_q;
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign rx_index   = rx_index_q;
  assign host_rdata = bank[host_addr];

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: bit-banged I2C master, open-drain SDA model,
// and a register-bank/pointer reference model kept at transaction level.
module tb_i2c_target;
  localparam int unsigned PTR_W = 3;
  localparam int unsigned NREGS = 8;
  localparam int          Q     = 5;

  logic             clk = 1'b0, rst = 1'b1;
  logic             scl_m = 1'b1, sda_m = 1'b1;
  logic             scl_in, sda_in, sda_oe, busy, rx_valid;
  logic [7:0]       rx_data, host_wdata = 8'h00, host_rdata;
  logic [PTR_W-1:0] rx_index, host_addr = '0;
  logic             host_we = 1'b0;

  int               total = 0, bad = 0;
  logic [7:0]       ref_bank [NREGS];
  int               ref_ptr = 0;
  logic [PTR_W+7:0] rx_q [$];
  logic [PTR_W+7:0] exp_rx [$];
  int               busy_cnt = 0, oe_cnt = 0;

  i2c_target #(.ADDR(7'h50), .NREGS(NREGS), .PTR_W(PTR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .busy(busy), .rx_valid(rx_valid), .rx_data(rx_data), .rx_index(rx_index),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;
  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back({rx_index, rx_data});
    if (busy) busy_cnt++;
    if (sda_oe) oe_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period starting and ending with SCL low; samples the line mid-high
  task automatic clock_bit(input logic b, output logic s, output logic o);
    tick(Q); sda_m = b; tick(Q); scl_m = 1'b1; tick(Q);
    s = sda_in; o = sda_oe;
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic bus_start();
    sda_m = 1'b0; tick(2*Q); scl_m = 1'b0;
  endtask

  task automatic bus_rstart();
    tick(Q); sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(2*Q); sda_m = 1'b0; tick(2*Q); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(2*Q); sda_m = 1'b1; tick(4*Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s, o;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s, o);
    clock_bit(1'b1, s, o);
    acked = o & ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s, o);
      d[i] = s;
    end
    clock_bit(~ack, s, o);
  endtask

  // Full write transaction to our address; updates the reference model
  task automatic do_write(input logic [7:0] ptrb, input logic [31:0] data, input int n, output int acks);
    logic a;
    acks = 0;
    bus_start();
    write_byte(8'hA0, a); acks += int'(a);
    write_byte(ptrb, a);  acks += int'(a);
    ref_ptr = int'(ptrb) % int'(NREGS);
    for (int i = 0; i < n; i++) begin
      write_byte(data[8*i +: 8], a); acks += int'(a);
      exp_rx.push_back({PTR_W'(ref_ptr), data[8*i +: 8]});
      ref_bank[ref_ptr] = data[8*i +: 8];
      ref_ptr = (ref_ptr + 1) % int'(NREGS);
    end
    bus_stop();
  endtask

  task automatic test_reset();
    tick(3); rst = 1'b0; tick(1);
    for (int i = 0; i < int'(NREGS); i++) ref_bank[i] = 8'h00;
    ref_ptr = 0;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL reset_sda_oe got=%b want=0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    total++; if ({rx_index, rx_data} !== '0) begin bad++; $display("FAIL reset_rx got=%h want=0", {rx_index, rx_data}); end
    for (int i = 0; i < int'(NREGS); i++) begin
      host_addr = PTR_W'(i); #1;
      total++; if (host_rdata !== ref_bank[i]) begin bad++; $display("FAIL reset_bank[%0d] got=%h want=%h", i, host_rdata, ref_bank[i]); end
    end
  endtask

  task automatic test_basic_write();
    int acks;
    do_write(8'h02, 32'h0000_00A5, 1, acks);
    total++; if (acks !== 3) begin bad++; $display("FAIL basic_acks got=%0d want=3", acks); end
    total++; if (rx_q.size() !== exp_rx.size()) begin bad++; $display("FAIL basic_rx_count got=%0d want=%0d", rx_q.size(), exp_rx.size()); end
    else if (rx_q[$] !== {PTR_W'(2), 8'hA5}) begin bad++; $display("FAIL basic_rx got=%h want=%h", rx_q[$], {PTR_W'(2), 8'hA5}); end
    host_addr = PTR_W'(2); #1;
    total++; if (host_rdata !== 8'hA5) begin bad++; $display("FAIL basic_bank2 got=%h want=a5", host_rdata); end
  endtask

  task automatic test_random_write();
    int acks, n;
    for (int t = 0; t < 5; t++) begin
      n = int'($urandom_range(1, 4));
      do_write(8'($urandom), $urandom, n, acks);
      total++; if (acks !== n + 2) begin bad++; $display("FAIL rand_acks[%0d] got=%0d want=%0d", t, acks, n + 2); end
    end
    total++; if (rx_q.size() !== exp_rx.size()) begin bad++; $display("FAIL rand_rx_count got=%0d want=%0d", rx_q.size(), exp_rx.size()); end
    else for (int i = 0; i < exp_rx.size(); i++) begin
      total++; if (rx_q[i] !== exp_rx[i]) begin bad++; $display("FAIL rand_rx[%0d] got=%h want=%h", i, rx_q[i], exp_rx[i]); end
    end
    for (int i = 0; i < int'(NREGS); i++) begin
      host_addr = PTR_W'(i); #1;
      total++; if (host_rdata !== ref_bank[i]) begin bad++; $display("FAIL rand_bank[%0d] got=%h want=%h", i, host_rdata, ref_bank[i]); end
    end
  endtask

  task automatic test_wrong_addr();
    logic [7:0] ab;
    logic a;
    int acks, b0, o0, r0;
    for (int t = 0; t < 4; t++) begin
      ab = (t == 0) ? 8'hA2 : 8'($urandom);
      if (ab[7:1] == 7'h50) ab[7:1] = 7'h51;
      b0 = busy_cnt; o0 = oe_cnt; r0 = rx_q.size(); acks = 0;
      bus_start();
      write_byte(ab, a); acks += int'(a);
      write_byte(8'h33, a); acks += int'(a);
      bus_stop();
      total++; if (acks !== 0) begin bad++; $display("FAIL wrong_addr_acks[%h] got=%0d want=0", ab, acks); end
      total++; if (oe_cnt !== o0) begin bad++; $display("FAIL wrong_addr_oe[%h] got=%0d cycles want=0", ab, oe_cnt - o0); end
      total++; if (busy_cnt !== b0) begin bad++; $display("FAIL wrong_addr_busy[%h] got=%0d cycles want=0", ab, busy_cnt - b0); end
      total++; if (rx_q.size() !== r0) begin bad++; $display("FAIL wrong_addr_rx[%h] got=%0d want=%0d", ab, rx_q.size(), r0); end
    end
    for (int i = 0; i < int'(NREGS); i++) begin
      host_addr = PTR_W'(i); #1;
      total++; if (host_rdata !== ref_bank[i]) begin bad++; $display("FAIL wrong_addr_bank[%0d] got=%h want=%h", i, host_rdata, ref_bank[i]); end
    end
  endtask

  task automatic test_read_wrap();
    logic a;
    logic [7:0] d, e;
    int acks;
    host_addr = PTR_W'(7); host_wdata = 8'h11; host_we = 1'b1; tick(1);
    host_addr = PTR_W'(0); host_wdata = 8'h22; tick(1); host_we = 1'b0;
    ref_bank[7] = 8'h11; ref_bank[0] = 8'h22;
    acks = 0;
    bus_start();
    write_byte(8'hA0, a); acks += int'(a);
    write_byte(8'h07, a); acks += int'(a);
    ref_ptr = 7;
    bus_rstart();
    write_byte(8'hA1, a); acks += int'(a);
    total++; if (acks !== 3) begin bad++; $display("FAIL read_wrap_acks got=%0d want=3", acks); end
    read_byte(1'b1, d); e = ref_bank[ref_ptr]; ref_ptr = (ref_ptr + 1) % int'(NREGS);
    total++; if (d !== e) begin bad++; $display("FAIL read_wrap_byte0 got=%h want=%h", d, e); end
    read_byte(1'b0, d); e = ref_bank[ref_ptr];
    total++; if (d !== e) begin bad++; $display("FAIL read_wrap_byte1 got=%h want=%h", d, e); end
    tick(Q);
    total++; if ({sda_oe, busy} !== 2'b00) begin bad++; $display("FAIL read_wrap_release got oe,busy=%b want=00", {sda_oe, busy}); end
    bus_stop();
  endtask

  task automatic test_read_random();
    logic a;
    logic [7:0] d, e;
    int acks, k;
    for (int t = 0; t < 3; t++) begin
      do_write(8'($urandom), 32'h0, 0, acks);
      k = int'($urandom_range(1, 3));
      bus_start(); write_byte(8'hA1, a);
      total++; if (a !== 1'b1) begin bad++; $display("FAIL read_rand_ack[%0d] got=%b want=1", t, a); end
      for (int j = 0; j < k; j++) begin
        read_byte(j != k - 1, d); e = ref_bank[ref_ptr];
        if (j != k - 1) ref_ptr = (ref_ptr + 1) % int'(NREGS);
        total++; if (d !== e) begin bad++; $display("FAIL read_rand[%0d.%0d] got=%h want=%h", t, j, d, e); end
      end
      bus_stop();
    end
    // Pointer persists into a fresh read transaction
    bus_start(); write_byte(8'hA1, a); read_byte(1'b0, d); bus_stop();
    e = ref_bank[ref_ptr];
    total++; if (d !== e) begin bad++; $display("FAIL read_persist got=%h want=%h", d, e); end
  endtask

  task automatic test_rst_mid();
    logic a, s, o;
    int r0;
    r0 = rx_q.size();
    bus_start(); write_byte(8'hA0, a); write_byte(8'h05, a);
    for (int i = 0; i < 4; i++) clock_bit(1'b1, s, o);
    scl_m = 1'b1; tick(Q);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy_before got=%b want=1", busy); end
    rst = 1'b1; tick(1); rst = 1'b0;
    total++; if ({sda_oe, busy} !== 2'b00) begin bad++; $display("FAIL rst_mid_after got oe,busy=%b want=00", {sda_oe, busy}); end
    for (int i = 0; i < int'(NREGS); i++) ref_bank[i] = 8'h00;
    ref_ptr = 0;
    scl_m = 1'b0; tick(Q); sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(4*Q);
    // Reset while the target is driving an ACK
    bus_start(); write_byte(8'hA0, a);
    for (int i = 0; i < 8; i++) clock_bit(1'b0, s, o);
    sda_m = 1'b1; tick(2*Q);
    total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL rst_ack_driving got=%b want=1", sda_oe); end
    rst = 1'b1; tick(1); rst = 1'b0;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rst_ack_release got=%b want=0", sda_oe); end
    tick(Q); scl_m = 1'b1; tick(4*Q);
    total++; if (rx_q.size() !== r0) begin bad++; $display("FAIL rst_mid_rx got=%0d want=%0d", rx_q.size(), r0); end
    for (int i = 0; i < int'(NREGS); i++) begin
      host_addr = PTR_W'(i); #1;
      total++; if (host_rdata !== ref_bank[i]) begin bad++; $display("FAIL rst_mid_bank[%0d] got=%h want=%h", i, host_rdata, ref_bank[i]); end
    end
  endtask

  task automatic test_collide(input int hidx);
    logic a, s, o;
    int w;
    bus_start(); write_byte(8'hA0, a); write_byte(8'h03, a);
    host_addr = PTR_W'(hidx); host_wdata = 8'h55; host_we = 1'b1;
    for (int i = 7; i >= 0; i--) clock_bit(1'(8'h66 >> i), s, o);
    w = 0;
    while (rx_valid !== 1'b1 && w < 40) begin tick(1); w++; end
    host_we = 1'b0;
    total++; if (w >= 40) begin bad++; $display("FAIL collide_pulse[%0d] got=timeout want=rx_valid", hidx); end
    clock_bit(1'b1, s, o);
    total++; if (o !== 1'b1) begin bad++; $display("FAIL collide_ack[%0d] got=%b want=1", hidx, o); end
    bus_stop();
    ref_bank[hidx] = 8'h55;
    ref_bank[3] = 8'h66;
    ref_ptr = 4;
    exp_rx.push_back({PTR_W'(3), 8'h66});
    total++; if (rx_q.size() !== exp_rx.size() || rx_q[$] !== exp_rx[$]) begin bad++; $display("FAIL collide_rx[%0d] got=%h want=%h", hidx, rx_q[$], exp_rx[$]); end
    for (int i = 0; i < int'(NREGS); i++) begin
      host_addr = PTR_W'(i); #1;
      total++; if (host_rdata !== ref_bank[i]) begin bad++; $display("FAIL collide[%0d]_bank[%0d] got=%h want=%h", hidx, i, host_rdata, ref_bank[i]); end
    end
  endtask

  task automatic test_stop_mid();
    logic a, s, o;
    logic [7:0] d, e, pb;
    int r0;
    r0 = rx_q.size();
    pb = 8'($urandom);
    bus_start(); write_byte(8'hA0, a); write_byte(pb, a);
    ref_ptr = int'(pb) % int'(NREGS);
    for (int i = 0; i < 5; i++) clock_bit(1'($urandom), s, o);
    bus_stop();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_mid_busy got=%b want=0", busy); end
    total++; if (rx_q.size() !== r0) begin bad++; $display("FAIL stop_mid_rx got=%0d want=%0d", rx_q.size(), r0); end
    for (int i = 0; i < int'(NREGS); i++) begin
      host_addr = PTR_W'(i); #1;
      total++; if (host_rdata !== ref_bank[i]) begin bad++; $display("FAIL stop_mid_bank[%0d] got=%h want=%h", i, host_rdata, ref_bank[i]); end
    end
    bus_start(); write_byte(8'hA1, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL stop_mid_next_ack got=%b want=1", a); end
    read_byte(1'b0, d); bus_stop();
    e = ref_bank[ref_ptr];
    total++; if (d !== e) begin bad++; $display("FAIL stop_mid_next_read got=%h want=%h", d, e); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_random_write();
    test_wrong_addr();
    test_read_wrap();
    test_read_random();
    test_rst_mid();
    test_basic_write();
    test_collide(3);
    test_collide(4);
    test_stop_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
